// File: rtl/aes_pkg.sv
// AES-128 shared constants and GF(2^8) helpers for the
// inverse round engine and its S-box leaves.
package aes_pkg;

  localparam int NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse, with 0 mapping to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rol8(
    input logic [7:0] b,
    input int         n
  );
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] =
          s[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                       ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                       ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                       ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                       ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box: inverse affine map followed by
// the GF(2^8) inverse; a pure 256-entry lookup.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = gf_inv(rol8(a_i, 1) ^ rol8(a_i, 3)
                    ^ rol8(a_i, 6) ^ 8'h05);
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: affine map applied to the GF(2^8)
// inverse; used by the key schedule SubWord.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  logic [7:0] x;

  assign x   = gf_inv(a_i);
  assign y_o = x ^ rol8(x, 1) ^ rol8(x, 2)
             ^ rol8(x, 3) ^ rol8(x, 4) ^ 8'h63;
endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES-128 decryptor: one inverse round per clock,
// round keys rewound from the round-10 key on the fly.
module aes_inv_round_engine
  import aes_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int NR     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_valid_in,
  input  logic              key_valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] key_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  if (DATA_W != 128 || NR != aes_pkg::NR) begin : g_bad_cfg
    $error("aes_inv_round_engine: only DATA_W=128, NR=10");
  end

  fsm_e         fsm_q, fsm_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         vld_q, vld_d;

  logic [31:0]  k0, k1, k2, k3, t3, rw, sw;
  logic [127:0] rk_prev, isr, isb, ark;

  // previous round key from rk[rnd+1]
  assign {k0, k1, k2, k3} = key_q;
  assign t3 = k3 ^ k2;
  assign rw = rot_word(t3);

  for (genvar i = 0; i < 4; i++) begin : g_sw
    aes_sbox u_sbox (
      .a_i(rw[31-8*i -: 8]),
      .y_o(sw[31-8*i -: 8])
    );
  end

  assign rk_prev = {k0 ^ sw ^ {RCON[rnd_q + 4'd1], 24'h0},
                    k1 ^ k0, k2 ^ k1, t3};

  assign isr = inv_shift_rows(st_q);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    aes_inv_sbox u_isbox (
      .a_i(isr[127-8*i -: 8]),
      .y_o(isb[127-8*i -: 8])
    );
  end

  assign ark = isb ^ rk_prev;

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    key_d = key_q;
    out_d = out_q;
    rnd_d = rnd_q;
    vld_d = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (data_valid_in && key_valid_in) begin
          st_d  = data_in ^ key_in;
          key_d = key_in;
          rnd_d = 4'd9;
          fsm_d = RUN;
        end
      end
      RUN: begin
        key_d = rk_prev;
        if (rnd_q != 4'd0) begin
          st_d  = inv_mix_columns(ark);
          rnd_d = rnd_q - 4'd1;
        end else begin
          out_d = ark;
          vld_d = 1'b1;
          fsm_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      key_q <= '0;
      out_q <= '0;
      rnd_q <= '0;
      vld_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      key_q <= key_d;
      out_q <= out_d;
      rnd_q <= rnd_d;
      vld_q <= vld_d;
    end
  end

  assign ready_out = (fsm_q == IDLE);
  assign valid_out = vld_q;
  assign data_out  = out_q;

endmodule
